fp_agg_scheduler: RTL and testbench
===================================

Name: fp_agg_scheduler

Overview:
- Sequences the fp_datapath aggregation engine.
- Watches per-port frame availability from the datapath input FIFOs against a configured port bitmap, and launches one aggregation round once every enabled port holds a frame.
- Flushes partial rounds when a straggler timeout expires.
- Exports round and timeout statistics for the register block.

Parameters:
NUM_QUEUES, 4, number of datapath input ports (bitmap width)
TIMEOUT_WIDTH, 16, width of straggler timeout value and timer
ROUND_CNT_WIDTH, 32, width of completed-round counter
DROP_CNT_WIDTH, 16, width of timeout/flush counter

Ports:
axis_aclk  in  1  clock
axis_reset  in  1  synchronous active-high reset
cfg_enable  in  1  scheduler enable
cfg_port_bitmap  in  NUM_QUEUES  ports participating in aggregation
cfg_timeout  in  TIMEOUT_WIDTH  straggler timeout in cycles; 0 disables the timeout
frame_avail  in  NUM_QUEUES  per-port "head frame present" (~fifo empty)
start_valid  out  1  request datapath to aggregate one round
start_mask  out  NUM_QUEUES  ports to consume in this round
start_ready  in  1  datapath accepts start
round_done  in  1  one-cycle pulse, datapath finished emitting the round
drop_valid  out  1  request datapath to discard head frames
drop_mask  out  NUM_QUEUES  ports whose head frame is discarded
drop_ready  in  1  datapath accepts drop
busy  out  1  high in any state other than IDLE
round_count  out  ROUND_CNT_WIDTH  completed rounds
timeout_count  out  DROP_CNT_WIDTH  flushed partial rounds

Behaviour:
- Reset (synchronous, axis_reset=1 at a rising edge):
  - state=IDLE; active_mask=0; timer=0.
  - All outputs are 0: start_valid, start_mask, drop_valid, drop_mask, busy, round_count, timeout_count.
  - Reset mid-round abandons the round immediately; no done or drop is awaited.
- States: IDLE, WAIT_ALL, ISSUE, BUSY, FLUSH.
- IDLE:
  - If cfg_enable=1 and cfg_port_bitmap!=0: latch active_mask<=cfg_port_bitmap, clear timer, go to WAIT_ALL next cycle.
  - Otherwise stay in IDLE.
- WAIT_ALL:
  - If (frame_avail & active_mask)==active_mask: go to ISSUE. This check has priority over the timeout in the same cycle.
  - Else if cfg_timeout!=0 and (frame_avail & active_mask)!=0: timer increments by 1.
    - When timer==cfg_timeout-1 and the masks still do not match, go to FLUSH and latch drop_mask<=frame_avail & active_mask.
  - If no masked port has a frame, timer holds at 0.
  - Config changes are ignored until the next IDLE.
- ISSUE:
  - start_valid=1 and start_mask=active_mask, held stable until start_ready=1.
  - On the handshake cycle go to BUSY; start_valid drops the following cycle.
- BUSY:
  - Wait for round_done. On round_done, round_count<=round_count+1 (wraps modulo 2^ROUND_CNT_WIDTH), then go to IDLE.
  - round_done in any other state is ignored.
- FLUSH:
  - drop_valid=1 with the latched drop_mask, held stable until drop_ready=1.
  - On the handshake, timeout_count increments (saturates at all-ones), then go to IDLE.
- Round latency: minimum 2 cycles from the all-available condition in WAIT_ALL to start_valid. That is one cycle to enter ISSUE; start_valid is registered.
- cfg_enable deasserted:
  - Takes effect only in IDLE or WAIT_ALL. WAIT_ALL returns to IDLE and the timer clears.
  - An in-flight ISSUE/BUSY/FLUSH always completes.
- Back-to-back rounds pass through IDLE, giving a minimum of 1 dead cycle between rounds. This guarantees the bitmap is re-sampled.
- Outputs are registered; start_mask and drop_mask are 0 whenever their valid is low.

Test Plan:
1. Full round: bitmap=4'hF, frame_avail=4'hF, start_ready=1 → start_valid high 1 cycle with start_mask=4'hF; after a round_done pulse, round_count=1 and busy=0.
2. Partial bitmap: bitmap=4'b1010, frame_avail=4'b1011 → start_mask=4'b1010; frame_avail=4'b0010 alone → no start.
3. Backpressure: start_ready low for 5 cycles → start_valid and start_mask held stable for 6 cycles and accepted on cycle 6; the same check applies to drop_valid with drop_ready.
4. Timeout: bitmap=4'hF, cfg_timeout=8, frame_avail=4'b0011 held → drop_valid asserted 8 cycles after the first partial-avail cycle with drop_mask=4'b0011; after the handshake, timeout_count=1. Repeat with cfg_timeout=0 → never flushes.
5. Simultaneous: in WAIT_ALL, the last missing port arrives on the timeout cycle → ISSUE taken, no drop, timeout_count unchanged.
6. Reset in BUSY: assert axis_reset for 1 cycle before round_done → all outputs 0, round_count=0; a later round_done pulse is ignored.

Source files
------------

// File: rtl/fp_agg_scheduler.sv
// Aggregation round sequencer for fp_datapath. It waits until every enabled port has a
// head frame, then requests a round. Partial rounds are flushed after a straggler timeout.
module fp_agg_scheduler #(
    parameter int NUM_QUEUES      = 4,
    parameter int TIMEOUT_WIDTH   = 16,
    parameter int ROUND_CNT_WIDTH = 32,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                       axis_aclk,
    input  logic                       axis_reset,
    input  logic                       cfg_enable,
    input  logic [NUM_QUEUES-1:0]      cfg_port_bitmap,
    input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
    input  logic [NUM_QUEUES-1:0]      frame_avail,
    output logic                       start_valid,
    output logic [NUM_QUEUES-1:0]      start_mask,
    input  logic                       start_ready,
    input  logic                       round_done,
    output logic                       drop_valid,
    output logic [NUM_QUEUES-1:0]      drop_mask,
    input  logic                       drop_ready,
    output logic                       busy,
    output logic [ROUND_CNT_WIDTH-1:0] round_count,
    output logic [DROP_CNT_WIDTH-1:0]  timeout_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ALL = 3'd1,
        ISSUE    = 3'd2,
        BUSY     = 3'd3,
        FLUSH    = 3'd4
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0]   TIMER_ONE = TIMEOUT_WIDTH'(1);
    localparam logic [ROUND_CNT_WIDTH-1:0] ROUND_ONE = ROUND_CNT_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0]  DROP_ONE  = DROP_CNT_WIDTH'(1);

    state_t                       state_q;
    logic [NUM_QUEUES-1:0]        active_mask_q;
    logic [TIMEOUT_WIDTH-1:0]     timeout_q;
    logic [TIMEOUT_WIDTH-1:0]     timer_q;
    logic                         start_valid_q;
    logic [NUM_QUEUES-1:0]        start_mask_q;
    logic                         drop_valid_q;
    logic [NUM_QUEUES-1:0]        drop_mask_q;
    logic                         busy_q;
    logic [ROUND_CNT_WIDTH-1:0]   round_count_q;
    logic [DROP_CNT_WIDTH-1:0]    timeout_count_q;

    logic [NUM_QUEUES-1:0]        avail_masked;
    logic                         all_avail;
    logic                         any_avail;
    logic                         timer_expire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_mask
            assign avail_masked[gi] = frame_avail[gi] & active_mask_q[gi];
        end
    endgenerate

    assign all_avail    = (avail_masked == active_mask_q);
    assign any_avail    = |avail_masked;
    assign timer_expire = (timer_q == timeout_q - TIMER_ONE);

    // Bitmap and timeout are captured on leaving IDLE so mid-round config writes cannot disturb a round.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q         <= IDLE;
            active_mask_q   <= '0;
            timeout_q       <= '0;
            timer_q         <= '0;
            start_valid_q   <= 1'b0;
            start_mask_q    <= '0;
            drop_valid_q    <= 1'b0;
            drop_mask_q     <= '0;
            busy_q          <= 1'b0;
            round_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_enable && (cfg_port_bitmap != '0)) begin
                        active_mask_q <= cfg_port_bitmap;
                        timeout_q     <= cfg_timeout;
                        timer_q       <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= WAIT_ALL;
                    end
                end
                WAIT_ALL: begin
                    if (!cfg_enable) begin
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (all_avail) begin
                        // A complete set wins over a timeout expiring in the same cycle.
                        timer_q <= '0;
                        state_q <= ISSUE;
                    end else if ((timeout_q != '0) && any_avail) begin
                        if (timer_expire) begin
                            timer_q      <= '0;
                            drop_valid_q <= 1'b1;
                            drop_mask_q  <= avail_masked;
                            state_q      <= FLUSH;
                        end else begin
                            timer_q <= timer_q + TIMER_ONE;
                        end
                    end else begin
                        timer_q <= '0;
                    end
                end
                ISSUE: begin
                    if (!start_valid_q) begin
                        start_valid_q <= 1'b1;
                        start_mask_q  <= active_mask_q;
                    end else if (start_ready) begin
                        start_valid_q <= 1'b0;
                        start_mask_q  <= '0;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    if (round_done) begin
                        round_count_q <= round_count_q + ROUND_ONE;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                FLUSH: begin
                    if (drop_ready) begin
                        drop_valid_q <= 1'b0;
                        drop_mask_q  <= '0;
                        if (timeout_count_q != '1) begin
                            timeout_count_q <= timeout_count_q + DROP_ONE;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_valid   = start_valid_q;
    assign start_mask    = start_mask_q;
    assign drop_valid    = drop_valid_q;
    assign drop_mask     = drop_mask_q;
    assign busy          = busy_q;
    assign round_count   = round_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_fp_agg_scheduler.sv
// Self-checking bench for fp_agg_scheduler: directed scenarios plus randomized rounds
// compared against a round-level outcome model (start / drop / nothing, mask, latency).
module tb_fp_agg_scheduler;

    logic        clk = 1'b0;
    logic        axis_reset;
    logic        cfg_enable;
    logic [3:0]  cfg_port_bitmap;
    logic [15:0] cfg_timeout;
    logic [3:0]  frame_avail;
    logic        start_valid;
    logic [3:0]  start_mask;
    logic        start_ready;
    logic        round_done;
    logic        drop_valid;
    logic [3:0]  drop_mask;
    logic        drop_ready;
    logic        busy;
    logic [31:0] round_count;
    logic [15:0] timeout_count;

    int errors = 0;
    int checks = 0;
    int exp_rounds = 0;
    int exp_timeouts = 0;

    fp_agg_scheduler dut (
        .axis_aclk       (clk),
        .axis_reset      (axis_reset),
        .cfg_enable      (cfg_enable),
        .cfg_port_bitmap (cfg_port_bitmap),
        .cfg_timeout     (cfg_timeout),
        .frame_avail     (frame_avail),
        .start_valid     (start_valid),
        .start_mask      (start_mask),
        .start_ready     (start_ready),
        .round_done      (round_done),
        .drop_valid      (drop_valid),
        .drop_mask       (drop_mask),
        .drop_ready      (drop_ready),
        .busy            (busy),
        .round_count     (round_count),
        .timeout_count   (timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic wait_valid(input int bound, output int cyc, output bit got_s, output bit got_d);
        got_s = 1'b0;
        got_d = 1'b0;
        cyc   = 0;
        while (cyc < bound && !got_s && !got_d) begin
            @(negedge clk);
            cyc++;
            got_s = start_valid;
            got_d = drop_valid;
        end
    endtask

    task automatic pulse_done();
        round_done = 1'b1;
        @(negedge clk);
        round_done = 1'b0;
    endtask

    task automatic do_reset();
        axis_reset      = 1'b1;
        cfg_enable      = 1'b0;
        cfg_port_bitmap = '0;
        cfg_timeout     = '0;
        frame_avail     = '0;
        start_ready     = 1'b0;
        drop_ready      = 1'b0;
        round_done      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        axis_reset   = 1'b0;
        exp_rounds   = 0;
        exp_timeouts = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({start_valid, start_mask, drop_valid, drop_mask, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got sv=%b sm=%h dv=%b dm=%h busy=%b need all 0",
                     start_valid, start_mask, drop_valid, drop_mask, busy);
        end
        checks++;
        if (round_count !== 32'd0 || timeout_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got rounds=%0d timeouts=%0d need 0 0", round_count, timeout_count);
        end
        $display("reset: outputs sampled after reset");
    endtask

    task automatic test_full_round();
        int cyc;
        bit gs, gd;
        cfg_timeout = 16'd0; cfg_port_bitmap = 4'hF; frame_avail = 4'hF;
        start_ready = 1'b1; cfg_enable = 1'b1;
        wait_valid(10, cyc, gs, gd);
        checks++;
        if (!gs || gd || cyc != 3 || start_mask !== 4'hF) begin
            errors++;
            $display("FAIL full_start: got start=%b drop=%b cyc=%0d mask=%h need 1 0 3 f", gs, gd, cyc, start_mask);
        end
        cfg_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (start_valid !== 1'b0 || start_mask !== 4'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_one_cycle: got sv=%b sm=%h busy=%b need 0 0 1", start_valid, start_mask, busy);
        end
        pulse_done();
        exp_rounds++;
        checks++;
        if (round_count !== 32'(exp_rounds) || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got rounds=%0d busy=%b need %0d 0", round_count, busy, exp_rounds);
        end
        $display("full_round: mask=f rounds=%0d", round_count);
    endtask

    task automatic test_partial_bitmap();
        int cyc;
        bit gs, gd;
        cfg_port_bitmap = 4'b1010; frame_avail = 4'b1011; cfg_enable = 1'b1;
        wait_valid(10, cyc, gs, gd);
        checks++;
        if (!gs || cyc != 3 || start_mask !== 4'b1010) begin
            errors++;
            $display("FAIL partial_start: got start=%b cyc=%0d mask=%b need 1 3 1010", gs, cyc, start_mask);
        end
        cfg_enable = 1'b0;
        @(negedge clk);
        pulse_done();
        exp_rounds++;
        checks++;
        if (round_count !== 32'(exp_rounds)) begin
            errors++;
            $display("FAIL partial_done: got rounds=%0d need %0d", round_count, exp_rounds);
        end
        frame_avail = 4'b0010; cfg_enable = 1'b1;
        wait_valid(30, cyc, gs, gd);
        checks++;
        if (gs || gd || busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_nostart: got start=%b drop=%b busy=%b need 0 0 1", gs, gd, busy);
        end
        cfg_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_disable: got busy=%b need 0", busy);
        end
        $display("partial_bitmap: mask=1010 then no start with avail=0010");
    endtask

    task automatic test_backpressure();
        int cyc;
        bit gs, gd;
        start_ready = 1'b0; cfg_port_bitmap = 4'hF; frame_avail = 4'hF; cfg_enable = 1'b1;
        wait_valid(10, cyc, gs, gd);
        cfg_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (start_valid !== 1'b1 || start_mask !== 4'hF) begin
                errors++;
                $display("FAIL bp_start_hold%0d: got sv=%b sm=%h need 1 f", i, start_valid, start_mask);
            end
            if (i == 5) start_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (start_valid !== 1'b0 || start_mask !== 4'h0) begin
            errors++;
            $display("FAIL bp_start_accept: got sv=%b sm=%h need 0 0", start_valid, start_mask);
        end
        pulse_done();
        exp_rounds++;
        checks++;
        if (round_count !== 32'(exp_rounds)) begin
            errors++;
            $display("FAIL bp_round: got rounds=%0d need %0d", round_count, exp_rounds);
        end
        $display("backpressure: start held 6 cycles");

        drop_ready = 1'b0; cfg_timeout = 16'd3; frame_avail = 4'b0001; cfg_enable = 1'b1;
        wait_valid(20, cyc, gs, gd);
        cfg_enable = 1'b0;
        checks++;
        if (!gd || gs || cyc != 4) begin
            errors++;
            $display("FAIL bp_drop_time: got drop=%b start=%b cyc=%0d need 1 0 4", gd, gs, cyc);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (drop_valid !== 1'b1 || drop_mask !== 4'b0001) begin
                errors++;
                $display("FAIL bp_drop_hold%0d: got dv=%b dm=%b need 1 0001", i, drop_valid, drop_mask);
            end
            if (i == 5) drop_ready = 1'b1;
            @(negedge clk);
        end
        exp_timeouts++;
        checks++;
        if (drop_valid !== 1'b0 || drop_mask !== 4'h0 || timeout_count !== 16'(exp_timeouts) || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop_accept: got dv=%b dm=%h to=%0d busy=%b need 0 0 %0d 0",
                     drop_valid, drop_mask, timeout_count, busy, exp_timeouts);
        end
        $display("backpressure: drop held 6 cycles, timeouts=%0d", timeout_count);
    endtask

    task automatic test_timeout();
        int cyc;
        bit gs, gd;
        drop_ready = 1'b1; cfg_timeout = 16'd8; cfg_port_bitmap = 4'hF; frame_avail = 4'b0011;
        cfg_enable = 1'b1;
        wait_valid(30, cyc, gs, gd);
        cfg_enable = 1'b0;
        checks++;
        if (!gd || gs || cyc != 9 || drop_mask !== 4'b0011) begin
            errors++;
            $display("FAIL timeout_drop: got drop=%b start=%b cyc=%0d mask=%b need 1 0 9 0011", gd, gs, cyc, drop_mask);
        end
        @(negedge clk);
        exp_timeouts++;
        checks++;
        if (drop_valid !== 1'b0 || timeout_count !== 16'(exp_timeouts)) begin
            errors++;
            $display("FAIL timeout_count: got dv=%b to=%0d need 0 %0d", drop_valid, timeout_count, exp_timeouts);
        end
        $display("timeout: drop mask=0011 after 8 cycles, timeouts=%0d", timeout_count);
        cfg_timeout = 16'd0; cfg_enable = 1'b1;
        wait_valid(60, cyc, gs, gd);
        checks++;
        if (gs || gd || timeout_count !== 16'(exp_timeouts)) begin
            errors++;
            $display("FAIL timeout_disabled: got start=%b drop=%b to=%0d need 0 0 %0d", gs, gd, timeout_count, exp_timeouts);
        end
        cfg_enable = 1'b0;
        @(negedge clk);
        $display("timeout: disabled timeout never flushes");
    endtask

    task automatic test_simultaneous();
        cfg_timeout = 16'd4; cfg_port_bitmap = 4'hF; frame_avail = 4'b0111; start_ready = 1'b1;
        cfg_enable = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        frame_avail = 4'hF;
        @(negedge clk);
        checks++;
        if (drop_valid !== 1'b0 || start_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_enter: got dv=%b sv=%b need 0 0", drop_valid, start_valid);
        end
        @(negedge clk);
        cfg_enable = 1'b0;
        checks++;
        if (start_valid !== 1'b1 || start_mask !== 4'hF || drop_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_issue: got sv=%b sm=%h dv=%b need 1 f 0", start_valid, start_mask, drop_valid);
        end
        @(negedge clk);
        pulse_done();
        exp_rounds++;
        checks++;
        if (round_count !== 32'(exp_rounds) || timeout_count !== 16'(exp_timeouts)) begin
            errors++;
            $display("FAIL simul_counts: got rounds=%0d to=%0d need %0d %0d",
                     round_count, timeout_count, exp_rounds, exp_timeouts);
        end
        $display("simultaneous: issue taken on timeout cycle, timeouts=%0d", timeout_count);
    endtask

    task automatic test_reset_in_busy();
        int cyc;
        bit gs, gd;
        do_reset();
        cfg_port_bitmap = 4'hF; frame_avail = 4'hF; start_ready = 1'b1; cfg_enable = 1'b1;
        wait_valid(10, cyc, gs, gd);
        cfg_enable = 1'b0;
        @(negedge clk);
        pulse_done();
        exp_rounds++;
        checks++;
        if (round_count !== 32'(exp_rounds)) begin
            errors++;
            $display("FAIL rib_first: got rounds=%0d need %0d", round_count, exp_rounds);
        end
        cfg_enable = 1'b1;
        wait_valid(10, cyc, gs, gd);
        cfg_enable = 1'b0;
        @(negedge clk);
        axis_reset = 1'b1;
        @(negedge clk);
        axis_reset = 1'b0;
        exp_rounds = 0;
        checks++;
        if ({start_valid, start_mask, drop_valid, drop_mask, busy} !== 11'd0 || round_count !== 32'd0) begin
            errors++;
            $display("FAIL rib_reset: got sv=%b dv=%b busy=%b rounds=%0d need 0 0 0 0",
                     start_valid, drop_valid, busy, round_count);
        end
        pulse_done();
        @(negedge clk);
        checks++;
        if (round_count !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rib_stale_done: got rounds=%0d busy=%b need 0 0", round_count, busy);
        end
        $display("reset_in_busy: round abandoned, late done ignored");
    endtask

    task automatic test_random();
        int cyc, kind, exp_cyc, dly;
        bit gs, gd;
        logic [3:0] bm, av, m, exp_mask;
        logic [15:0] to;
        for (int it = 0; it < 40; it++) begin
            bm  = 4'($urandom_range(1, 15));
            av  = 4'($urandom_range(0, 15));
            to  = 16'($urandom_range(1, 6));
            dly = $urandom_range(0, 3);
            m   = av & bm;
            if (m == bm) begin
                kind = 1; exp_cyc = 3; exp_mask = bm;
            end else if (m != 4'h0) begin
                kind = 2; exp_cyc = int'(to) + 1; exp_mask = m;
            end else begin
                kind = 0; exp_cyc = 0; exp_mask = 4'h0;
            end
            cfg_port_bitmap = bm; frame_avail = av; cfg_timeout = to;
            start_ready = (dly == 0); drop_ready = (dly == 0);
            cfg_enable = 1'b1;
            wait_valid(12, cyc, gs, gd);
            cfg_enable = 1'b0;
            checks++;
            if (gs !== (kind == 1) || gd !== (kind == 2) || (kind != 0 && cyc != exp_cyc)) begin
                errors++;
                $display("FAIL rnd%0d_outcome: got start=%b drop=%b cyc=%0d need start=%b drop=%b cyc=%0d",
                         it, gs, gd, cyc, kind == 1, kind == 2, exp_cyc);
            end
            if (kind == 1) begin
                for (int i = 0; i < dly; i++) begin
                    checks++;
                    if (start_valid !== 1'b1 || start_mask !== exp_mask) begin
                        errors++;
                        $display("FAIL rnd%0d_start_hold: got sv=%b sm=%h need 1 %h", it, start_valid, start_mask, exp_mask);
                    end
                    @(negedge clk);
                end
                checks++;
                if (start_valid !== 1'b1 || start_mask !== exp_mask) begin
                    errors++;
                    $display("FAIL rnd%0d_start_mask: got sv=%b sm=%h need 1 %h", it, start_valid, start_mask, exp_mask);
                end
                start_ready = 1'b1;
                @(negedge clk);
                pulse_done();
                exp_rounds++;
            end else if (kind == 2) begin
                for (int i = 0; i < dly; i++) begin
                    checks++;
                    if (drop_valid !== 1'b1 || drop_mask !== exp_mask) begin
                        errors++;
                        $display("FAIL rnd%0d_drop_hold: got dv=%b dm=%h need 1 %h", it, drop_valid, drop_mask, exp_mask);
                    end
                    @(negedge clk);
                end
                checks++;
                if (drop_valid !== 1'b1 || drop_mask !== exp_mask) begin
                    errors++;
                    $display("FAIL rnd%0d_drop_mask: got dv=%b dm=%h need 1 %h", it, drop_valid, drop_mask, exp_mask);
                end
                drop_ready = 1'b1;
                @(negedge clk);
                exp_timeouts++;
            end else begin
                @(negedge clk);
            end
            checks++;
            if (busy !== 1'b0 || start_valid !== 1'b0 || drop_valid !== 1'b0 ||
                round_count !== 32'(exp_rounds) || timeout_count !== 16'(exp_timeouts)) begin
                errors++;
                $display("FAIL rnd%0d_end: got busy=%b sv=%b dv=%b rounds=%0d to=%0d need 0 0 0 %0d %0d",
                         it, busy, start_valid, drop_valid, round_count, timeout_count, exp_rounds, exp_timeouts);
            end
            $display("rnd%0d: bitmap=%b avail=%b timeout=%0d delay=%0d kind=%0d rounds=%0d timeouts=%0d",
                     it, bm, av, to, dly, kind, round_count, timeout_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_partial_bitmap();
        test_backpressure();
        test_timeout();
        test_simultaneous();
        test_reset_in_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
